i2c_slave_regfile: RTL

Parametrised I2C target with an internal byte register file, pointer-based burst access and a local host port. It is the successor to the single-byte I2C slave: it adds synchronised and edge-detected SCL/SDA, true open-drain ACK/NACK, repeated START, a multi-byte write/read burst with auto-incrementing pointer, and a host-side register interface. It sits between the board I2C bus and on-chip control logic.

---
 rtl/i2c_slave_regfile.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_regfile.sv
// I2C target with a byte register file, auto-incrementing pointer bursts and a host port.
// SCL/SDA are synchronised and edge-detected; SDA is open-drain (0 or 'z').
module i2c_slave_regfile #(
  parameter logic [6:0]  ADDRESS = 7'h51,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned PTR_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scl,
  inout  wire              sda,
  input  logic             host_we,
  input  logic [PTR_W-1:0] host_addr,
  input  logic [7:0]       host_wdata,
  output logic [7:0]       host_rdata,
  output logic             wr_valid,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic             busy
);

  localparam logic [3:0] StIdle     = 4'd0;
  localparam logic [3:0] StAddr     = 4'd1;
  localparam logic [3:0] StAddrAck  = 4'd2;
  localparam logic [3:0] StPtr      = 4'd3;
  localparam logic [3:0] StPtrAck   = 4'd4;
  localparam logic [3:0] StWdata    = 4'd5;
  localparam logic [3:0] StWdataAck = 4'd6;
  localparam logic [3:0] StRdata    = 4'd7;
  localparam logic [3:0] StRack     = 4'd8;
  localparam logic [3:0] StIgnore   = 4'd9;

  logic scl_meta, scl_sync, scl_prev;
  logic sda_meta, sda_sync, sda_prev;
  logic scl_rise, scl_fall, start_det, stop_det;

  logic [3:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             oe_q, oe_d;
  logic             ack_q, ack_d;
  logic             rw_q, rw_d;
  logic             busy_q, busy_d;
  logic             bus_we;
  logic [7:0]       byte_in, rd_byte;
  logic [PTR_W-1:0] ptr_inc;

  logic [7:0] regs [DEPTH];

  assign sda = oe_q ? 1'b0 : 1'bz;

  // Synchronisers reset to the idle-high bus level so reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      {scl_meta, scl_sync, scl_prev} <= 3'b111;
      {sda_meta, sda_sync, sda_prev} <= 3'b111;
    end else begin
      {scl_meta, scl_sync, scl_prev} <= {scl, scl_meta, scl_sync};
      {sda_meta, sda_sync, sda_prev} <= {sda, sda_meta, sda_sync};
    end
  end

  assign scl_rise  = scl_sync & ~scl_prev;
  assign scl_fall  = ~scl_sync & scl_prev;
  assign start_det = scl_sync & scl_prev & ~sda_sync & sda_prev;
  assign stop_det  = scl_sync & scl_prev & sda_sync & ~sda_prev;

  assign byte_in = {shift_q[6:0], sda_sync};
  assign rd_byte = regs[ptr_q];
  assign ptr_inc = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    ptr_d   = ptr_q;
    oe_d    = oe_q;
    ack_d   = ack_q;
    rw_d    = rw_q;
    busy_d  = busy_q;
    bus_we  = 1'b0;
    if (stop_det) begin
      state_d = StIdle;
      oe_d    = 1'b0;
      ack_d   = 1'b0;
      busy_d  = 1'b0;
    end else if (start_det) begin
      state_d = StAddr;
      cnt_d   = '0;
      oe_d    = 1'b0;
      ack_d   = 1'b0;
    end else begin
      case (state_q)
        StAddr, StPtr, StWdata: begin
          if (scl_rise) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = '0;
              if (state_q == StAddr) begin
                if (byte_in[7:1] == ADDRESS) begin
                  state_d = StAddrAck;
                  busy_d  = 1'b1;
                  rw_d    = byte_in[0];
                end else begin
                  state_d = StIgnore;
                  busy_d  = 1'b0;
                end
              end else if (state_q == StPtr) begin
                if (32'(byte_in) < DEPTH) begin
                  ptr_d   = PTR_W'(byte_in);
                  state_d = StPtrAck;
                end else begin
                  state_d = StIgnore;
                  busy_d  = 1'b0;
                end
              end else begin
                bus_we  = 1'b1;
                ptr_d   = ptr_inc;
                state_d = StWdataAck;
              end
            end
          end
        end
        // First fall drives the ACK low, second fall ends the ACK bit.
        StAddrAck, StPtrAck, StWdataAck: begin
          if (scl_fall) begin
            if (!ack_q) begin
              oe_d  = 1'b1;
              ack_d = 1'b1;
            end else begin
              ack_d = 1'b0;
              oe_d  = 1'b0;
              cnt_d = '0;
              if (state_q == StAddrAck && rw_q) begin
                state_d = StRdata;
                shift_d = rd_byte;
                oe_d    = ~rd_byte[7];
              end else if (state_q == StAddrAck) begin
                state_d = StPtr;
              end else begin
                state_d = StWdata;
              end
            end
          end
        end
        StRdata: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              oe_d    = 1'b0;
              cnt_d   = '0;
              ptr_d   = ptr_inc;
              state_d = StRack;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              oe_d    = ~shift_q[6];
            end
          end
        end
        StRack: begin
          if (scl_rise) begin
            if (!sda_sync) begin
              ack_d = 1'b1;
            end else begin
              state_d = StIgnore;
              busy_d  = 1'b0;
            end
          end else if (scl_fall && ack_q) begin
            ack_d   = 1'b0;
            cnt_d   = '0;
            shift_d = rd_byte;
            oe_d    = ~rd_byte[7];
            state_d = StRdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      shift_q  <= '0;
      ptr_q    <= '0;
      oe_q     <= 1'b0;
      ack_q    <= 1'b0;
      rw_q     <= 1'b0;
      busy_q   <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      ptr_q    <= ptr_d;
      oe_q     <= oe_d;
      ack_q    <= ack_d;
      rw_q     <= rw_d;
      busy_q   <= busy_d;
      wr_valid <= bus_we;
      if (bus_we) begin
        wr_addr <= ptr_q;
        wr_data <= byte_in;
      end
    end
  end

  assign busy = busy_q;

  // Host write is applied last so it wins a same-cycle collision with the bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs       <= '{default: '0};
      host_rdata <= '0;
    end else begin
      if (bus_we) begin
        regs[ptr_q] <= byte_in;
      end
      if (host_we && (32'(host_addr) < DEPTH)) begin
        regs[host_addr] <= host_wdata;
      end
      host_rdata <= (32'(host_addr) < DEPTH) ? regs[host_addr] : 8'h00;
    end
  end

endmodule
